// File: rtl/nebula_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nebula_mem_arbiter
// Brief    : Round-robin 2:1 arbiter sharing one 512-bit line memory port
//            between the I-cache and D-cache refill/writeback paths.
// Revision : 1.0 - initial release
// ============================================================================
module nebula_mem_arbiter #(
    parameter int PADDR_WIDTH    = 56,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   imem_req,
    input  logic [PADDR_WIDTH-1:0] imem_addr,
    output logic                   imem_ack,
    output logic [511:0]           imem_data,
    input  logic                   dmem_req,
    input  logic                   dmem_we,
    input  logic [PADDR_WIDTH-1:0] dmem_addr,
    input  logic [511:0]           dmem_wdata,
    output logic                   dmem_ack,
    output logic [511:0]           dmem_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [PADDR_WIDTH-1:0] mem_addr,
    output logic [511:0]           mem_wdata,
    input  logic                   mem_ack,
    input  logic [511:0]           mem_rdata,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
    localparam logic        c_OWN_I   = 1'b0;
    localparam logic        c_OWN_D   = 1'b1;

    state_t                   r_state_q,      w_state_d;
    logic                     r_owner_q,      w_owner_d;
    logic                     r_last_owner_q, w_last_owner_d;
    logic [1:0]               r_mask_q,       w_mask_d;
    logic [15:0]              r_wdog_q,       w_wdog_d;
    logic                     r_timeout_q,    w_timeout_d;
    logic                     r_mem_req_q,    w_mem_req_d;
    logic                     r_mem_we_q,     w_mem_we_d;
    logic [PADDR_WIDTH-1:0]   r_mem_addr_q,   w_mem_addr_d;
    logic [511:0]             r_mem_wdata_q,  w_mem_wdata_d;
    logic                     r_imem_ack_q,   w_imem_ack_d;
    logic [511:0]             r_imem_data_q,  w_imem_data_d;
    logic                     r_dmem_ack_q,   w_dmem_ack_d;
    logic [511:0]             r_dmem_rdata_q, w_dmem_rdata_d;
    logic                     r_busy_q,       w_busy_d;

    logic w_elig_i;
    logic w_elig_d;
    logic w_win_d;
    logic w_grant;

    // Mask bit 0 = I, bit 1 = D; only non-zero while in HOLD.
    assign w_elig_i = imem_req & ~r_mask_q[0];
    assign w_elig_d = dmem_req & ~r_mask_q[1];
    assign w_grant  = w_elig_i | w_elig_d;
    assign w_win_d  = w_elig_d & (~w_elig_i | (r_last_owner_q == c_OWN_I));

    always_comb begin
        w_state_d      = r_state_q;
        w_owner_d      = r_owner_q;
        w_last_owner_d = r_last_owner_q;
        w_mask_d       = r_mask_q;
        w_wdog_d       = r_wdog_q;
        w_timeout_d    = r_timeout_q;
        w_mem_req_d    = r_mem_req_q;
        w_mem_we_d     = r_mem_we_q;
        w_mem_addr_d   = r_mem_addr_q;
        w_mem_wdata_d  = r_mem_wdata_q;
        w_imem_ack_d   = r_imem_ack_q;
        w_imem_data_d  = r_imem_data_q;
        w_dmem_ack_d   = r_dmem_ack_q;
        w_dmem_rdata_d = r_dmem_rdata_q;

        case (r_state_q)
            ST_IDLE, ST_HOLD: begin
                w_mask_d = 2'b00;
                if (w_grant) begin
                    w_state_d      = ST_ISSUE;
                    w_mem_req_d    = 1'b1;
                    w_owner_d      = w_win_d;
                    w_last_owner_d = w_win_d;
                    w_wdog_d       = 16'd0;
                    if (w_win_d) begin
                        w_mem_addr_d  = dmem_addr;
                        w_mem_we_d    = dmem_we;
                        w_mem_wdata_d = dmem_wdata;
                    end else begin
                        w_mem_addr_d  = imem_addr;
                        w_mem_we_d    = 1'b0;
                    end
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Saturating watchdog: the transaction keeps waiting after it fires.
                if (r_wdog_q != c_TIMEOUT) begin
                    w_wdog_d = r_wdog_q + 16'd1;
                end
                if (w_wdog_d == c_TIMEOUT) begin
                    w_timeout_d = 1'b1;
                end
                if (mem_ack) begin
                    w_state_d   = ST_RESP;
                    w_mem_req_d = 1'b0;
                    if (r_owner_q == c_OWN_I) begin
                        w_imem_ack_d  = 1'b1;
                        w_imem_data_d = mem_rdata;
                    end else begin
                        w_dmem_ack_d = 1'b1;
                        if (!r_mem_we_q) begin
                            w_dmem_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            ST_RESP: begin
                w_state_d    = ST_HOLD;
                w_imem_ack_d = 1'b0;
                w_dmem_ack_d = 1'b0;
                w_mask_d     = (r_owner_q == c_OWN_D) ? 2'b10 : 2'b01;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_owner_q      <= c_OWN_I;
            r_last_owner_q <= c_OWN_D;
            r_mask_q       <= 2'b00;
            r_wdog_q       <= 16'd0;
            r_timeout_q    <= 1'b0;
            r_mem_req_q    <= 1'b0;
            r_mem_we_q     <= 1'b0;
            r_mem_addr_q   <= '0;
            r_mem_wdata_q  <= '0;
            r_imem_ack_q   <= 1'b0;
            r_imem_data_q  <= '0;
            r_dmem_ack_q   <= 1'b0;
            r_dmem_rdata_q <= '0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_owner_q      <= w_owner_d;
            r_last_owner_q <= w_last_owner_d;
            r_mask_q       <= w_mask_d;
            r_wdog_q       <= w_wdog_d;
            r_timeout_q    <= w_timeout_d;
            r_mem_req_q    <= w_mem_req_d;
            r_mem_we_q     <= w_mem_we_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_wdata_q  <= w_mem_wdata_d;
            r_imem_ack_q   <= w_imem_ack_d;
            r_imem_data_q  <= w_imem_data_d;
            r_dmem_ack_q   <= w_dmem_ack_d;
            r_dmem_rdata_q <= w_dmem_rdata_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign imem_ack    = r_imem_ack_q;
    assign imem_data   = r_imem_data_q;
    assign dmem_ack    = r_dmem_ack_q;
    assign dmem_rdata  = r_dmem_rdata_q;
    assign mem_req     = r_mem_req_q;
    assign mem_we      = r_mem_we_q;
    assign mem_addr    = r_mem_addr_q;
    assign mem_wdata   = r_mem_wdata_q;
    assign busy        = r_busy_q;
    assign timeout_err = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_nebula_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nebula_mem_arbiter
// Brief    : Directed self-checking bench for nebula_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nebula_mem_arbiter;

    localparam int c_AW = 56;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [c_AW-1:0] imem_addr;
    logic            imem_ack;
    logic [511:0]    imem_data;
    logic            dmem_req;
    logic            dmem_we;
    logic [c_AW-1:0] dmem_addr;
    logic [511:0]    dmem_wdata;
    logic            dmem_ack;
    logic [511:0]    dmem_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [511:0]    mem_wdata;
    logic            mem_ack;
    logic [511:0]    mem_rdata;
    logic            busy;
    logic            timeout_err;

    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [511:0] exp_idata;
    logic [511:0] exp_drdata;

    always #5 clk = ~clk;

    nebula_mem_arbiter #(
        .PADDR_WIDTH    (c_AW),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_idata  = '0;
        exp_drdata = '0;
    endtask

    // Starts just before the grant edge and returns in the HOLD cycle.
    task automatic serve(input bit is_d, input logic [c_AW-1:0] addr, input bit we,
                         input logic [511:0] wd, input logic [511:0] rd, input int lat,
                         input bit keep, input bit raise_other);
        tick();
        chk("grant_req", mem_req, 1'b1);
        chk("grant_addr", mem_addr, addr);
        chk("grant_we", mem_we, we);
        if (is_d && we) chk("grant_wdata", mem_wdata, wd);
        chk("issue_busy", busy, 1'b1);
        if (raise_other) begin
            if (is_d) imem_req = 1'b1;
            else      dmem_req = 1'b1;
        end
        for (int n = 1; n < lat; n++) begin
            tick();
            chk("issue_req_held", mem_req, 1'b1);
            chk("issue_addr_held", mem_addr, addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = {16{32'hDEADBEEF}};
        if (!is_d)   exp_idata  = rd;
        else if (!we) exp_drdata = rd;
        chk("resp_mem_req", mem_req, 1'b0);
        chk("resp_imem_ack", imem_ack, !is_d);
        chk("resp_dmem_ack", dmem_ack, is_d);
        chk("resp_imem_data", imem_data, exp_idata);
        chk("resp_dmem_rdata", dmem_rdata, exp_drdata);
        if (!keep) begin
            if (is_d) dmem_req = 1'b0;
            else      imem_req = 1'b0;
        end
        tick();
        chk("hold_imem_ack", imem_ack, 1'b0);
        chk("hold_dmem_ack", dmem_ack, 1'b0);
        chk("hold_busy", busy, 1'b1);
        chk("hold_mem_req", mem_req, 1'b0);
        chk("hold_imem_data", imem_data, exp_idata);
        chk("hold_dmem_rdata", dmem_rdata, exp_drdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [511:0] rd;
        logic [511:0] wd;
        logic [7:0]   b;
        bit           is_d;

        rst = 1'b1; imem_req = 1'b0; imem_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        do_reset();

        // Reset state
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_imem_ack", imem_ack, 1'b0);
        chk("rst_dmem_ack", dmem_ack, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_imem_data", imem_data, '0);

        // I only, request held through HOLD (stale masking)
        imem_req  = 1'b1;
        imem_addr = 56'h1000;
        rd = {64{8'hA5}};
        serve(1'b0, 56'h1000, 1'b0, '0, rd, 2, 1'b1, 1'b0);
        tick();
        chk("stale_no_regrant", mem_req, 1'b0);
        chk("stale_idle", busy, 1'b0);
        chk("stale_dmem_ack", dmem_ack, 1'b0);
        imem_req = 1'b0;
        tick();
        chk("idle_mem_req", mem_req, 1'b0);
        chk("idle_imem_data", imem_data, {64{8'hA5}});

        // Spurious downstream ack in IDLE
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("spur_imem_ack", imem_ack, 1'b0);
        chk("spur_dmem_ack", dmem_ack, 1'b0);
        chk("spur_busy", busy, 1'b0);

        // Tie after reset: I, D, I, D, I with no idle gap
        do_reset();
        imem_addr = 56'h2000;
        dmem_addr = 56'h3000;
        dmem_we   = 1'b0;
        imem_req  = 1'b1;
        dmem_req  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            is_d = ((k % 2) == 1);
            b    = 8'h10 + 8'(k);
            rd   = {64{b}};
            serve(is_d, is_d ? 56'h3000 : 56'h2000, 1'b0, '0, rd, 1 + (k % 2), 1'b0, 1'b0);
            if (is_d) dmem_req = 1'b1;
            else      imem_req = 1'b1;
        end
        imem_req = 1'b0;
        dmem_req = 1'b0;
        tick();
        chk("tie_end_idle", busy, 1'b0);

        // D write with I arriving mid-ISSUE
        wd = {16{32'h12345678}};
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = 56'h40;
        dmem_wdata = wd;
        imem_addr  = 56'h5000;
        serve(1'b1, 56'h40, 1'b1, wd, {64{8'h99}}, 3, 1'b0, 1'b1);
        dmem_we = 1'b0;
        serve(1'b0, 56'h5000, 1'b0, '0, {64{8'h5C}}, 1, 1'b0, 1'b0);
        chk("i_keeps_wdata", mem_wdata, wd);
        chk("wr_rdata_kept", dmem_rdata, exp_drdata);
        tick();
        chk("wr_end_idle", busy, 1'b0);

        // Watchdog with TIMEOUT_CYCLES = 8
        imem_req  = 1'b1;
        imem_addr = 56'h6000;
        tick();
        chk("wd_grant", mem_req, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            chk("wd_not_yet", timeout_err, 1'b0);
            tick();
        end
        chk("wd_fired", timeout_err, 1'b1);
        chk("wd_still_waiting", mem_req, 1'b1);
        tick();
        tick();
        chk("wd_sticky", timeout_err, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = {64{8'h77}};
        tick();
        mem_ack  = 1'b0;
        imem_req = 1'b0;
        chk("wd_late_ack", imem_ack, 1'b1);
        chk("wd_late_data", imem_data, {64{8'h77}});
        tick();
        tick();
        chk("wd_idle", busy, 1'b0);
        chk("wd_sticky_idle", timeout_err, 1'b1);

        // Reset while in ISSUE
        dmem_req  = 1'b1;
        dmem_addr = 56'h80;
        tick();
        chk("rs_grant", mem_req, 1'b1);
        dmem_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_mem_req", mem_req, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_imem_ack", imem_ack, 1'b0);
        chk("rs_dmem_ack", dmem_ack, 1'b0);
        chk("rs_timeout", timeout_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nebula_mem_arbiter.md
# nebula_mem_arbiter

Two-to-one arbiter that lets the Nebula I-cache and D-cache refill/writeback paths share a single native 512-bit cache-line memory port. It sits between the caches and one port of the AXI adapter, or any single-ported native memory model. It grants one line transaction at a time with round-robin fairness, registers the winning request downstream and routes the single-cycle ack and read data back to the owner. It also masks the served requester for one cycle so a stale level request is never re-issued.

## Interface
- PADDR_WIDTH, 56: physical address width.
- TIMEOUT_CYCLES, 1024: ISSUE-state cycle count at which `timeout_err` is raised; valid range 2..65535.

- clk  in  1: clock, all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- imem_req  in  1: I-side level request, held until `imem_ack`.
- imem_addr  in  PADDR_WIDTH: I-side line address.
- imem_ack  out  1: one-cycle completion pulse to I-side.
- imem_data  out  512: I-side read line, valid with `imem_ack` and held afterwards.
- dmem_req  in  1: D-side level request, held until `dmem_ack`.
- dmem_we  in  1: 1 = line write, 0 = line read.
- dmem_addr  in  PADDR_WIDTH: D-side line address.
- dmem_wdata  in  512: D-side write line.
- dmem_ack  out  1: one-cycle completion pulse to D-side.
- dmem_rdata  out  512: D-side read line, valid with `dmem_ack` for reads and held afterwards.
- mem_req  out  1: downstream level request.
- mem_we  out  1: downstream write enable.
- mem_addr  out  PADDR_WIDTH: downstream address.
- mem_wdata  out  512: downstream write line.
- mem_ack  in  1: downstream one-cycle completion.
- mem_rdata  in  512: downstream read line, valid with `mem_ack`.
- busy  out  1: high in every state except IDLE.
- timeout_err  out  1: sticky watchdog flag.

## Operation
- Reset: all outputs are 0. State = IDLE. `last_owner` = D, so I wins the first tie. The mask and the watchdog counter are cleared.
- States: IDLE, ISSUE, RESP, HOLD.
- Arbitration runs in IDLE and HOLD over the eligible requests.
  - In HOLD, the requester served in the preceding RESP is ineligible.
  - One eligible request: it wins.
  - Both eligible: the requester that is not `last_owner` wins.
  - No eligible request: HOLD moves to IDLE; IDLE stays in IDLE.
- Grant (IDLE/HOLD → ISSUE):
  - Register `mem_req`=1 and `mem_addr` from the winner.
  - D winner: `mem_we` = `dmem_we`, `mem_wdata` = `dmem_wdata`.
  - I winner: `mem_we` = 0; `mem_wdata` keeps its previous value.
  - Set `owner` to the winner, update `last_owner`, clear the watchdog counter.
- ISSUE: `mem_*` outputs are held stable. Requester inputs are ignored; no re-sampling.
- ISSUE → RESP on `mem_ack`:
  - Drop `mem_req`.
  - Register the owner's ack to 1.
  - If `owner` = I: load `imem_data` from `mem_rdata`.
  - If `owner` = D and the transaction is a read: load `dmem_rdata` from `mem_rdata`.
  - D writes leave `dmem_rdata` unchanged.
- RESP → HOLD unconditionally; the ack returns to 0.
- The non-owner's ack is never asserted, and its data output never changes, during another requester's transaction.
- `mem_ack` outside ISSUE is ignored and causes no ack. `mem_rdata` outside the capture cycle is ignored.
- Watchdog:
  - The counter increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES, `timeout_err` is set and stays set until `rst`.
  - The transaction is not aborted; the arbiter keeps waiting for `mem_ack`.
  - The counter saturates and does not wrap.
- Requester dropping `req` during ISSUE is a protocol violation. The transaction still completes and the ack is still pulsed.
- Reset mid-transaction returns to IDLE with `mem_req` low next cycle. The downstream adapter must be reset in the same cycle.

## Timing
- The winner's `req` is sampled in cycle T. `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are valid at T+1.
- `mem_ack` is sampled at cycle K. The owner's ack and data are valid at K+1, for exactly one cycle; `mem_req` is low from K+1.
- Requesters must deassert `req` by the cycle after they see their ack.
- The earliest next grant is sampled in HOLD (K+2), and only the other requester can win there. The acked requester can next be granted from IDLE at K+3.
- Minimum service: 3 cycles overhead plus downstream latency. Back-to-back alternation costs no idle cycle between transactions.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- I only: `imem_req`=1, addr 0x1000; downstream acks 2 cycles after `mem_req` with rdata A5..A5 -> `mem_req`=1 at T+1 with `mem_we`=0 and `mem_addr`=0x1000; `imem_ack` pulses once with `imem_data`=A5..A5; `dmem_ack` stays 0; no second `mem_req` while `imem_req` is held through HOLD.
- Tie after reset: both reqs rise together -> I granted first, then D granted directly from HOLD; repeating the tie alternates D, I, D, I; each ack goes only to its owner.
- D write: `dmem_we`=1, addr 0x40, wdata 0x1234..; `imem_req` arrives mid-ISSUE -> downstream sees `we`=1 and the exact wdata; `dmem_rdata` is unchanged; I is granted in HOLD.
- Stale-request masking: the requester holds `req` one extra cycle after its ack and the other requester is idle -> no regrant in HOLD; a single transaction only.
- Watchdog: TIMEOUT_CYCLES=8, downstream never acks -> `timeout_err` rises after 8 ISSUE cycles and stays high; a late ack still completes the transaction.
- Reset in ISSUE: assert `rst` for 1 cycle -> next cycle `mem_req`=0, `busy`=0, both acks 0, `timeout_err`=0.
